// File: rtl/hazard_scoreboard_unit_if.sv
// Decode-side bus of the hazard scoreboard: decode/pipeline control in,
// stall, bubble, forwarding selects and stall statistics out.
interface hazard_scoreboard_unit_if #(
  parameter int NSRC  = 3,
  parameter int SEL_W = 2,
  parameter int CNT_W = 32
) ();
  logic                    ds_valid;
  logic [NSRC*5-1:0]       ds_src;
  logic [NSRC-1:0]         ds_src_en;
  logic [4:0]              ds_dest;
  logic                    ds_we;
  logic                    ds_is_load;
  logic                    pipe_adv;
  logic                    mdu_busy;
  logic                    flush;
  logic                    ds_stall;
  logic                    es_bubble;
  logic [NSRC*SEL_W-1:0]   fwd_sel;
  logic [CNT_W-1:0]        stall_cnt;

  // Pipeline/decode side: drives the request, observes the decision.
  modport master (
    output ds_valid, ds_src, ds_src_en, ds_dest, ds_we, ds_is_load,
    output pipe_adv, mdu_busy, flush,
    input  ds_stall, es_bubble, fwd_sel, stall_cnt
  );

  // Hazard unit side.
  modport slave (
    input  ds_valid, ds_src, ds_src_en, ds_dest, ds_we, ds_is_load,
    input  pipe_adv, mdu_busy, flush,
    output ds_stall, es_bubble, fwd_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard scoreboard: tracks in-flight GPR writers after decode in a shift
// register (entry 0 = EX, youngest) and resolves RAW hazards for the decode
// sources: forwarding selects, load-use stall, multi-cycle-unit stall,
// EX bubble insertion and a saturating stall-cycle counter.
module hazard_scoreboard_unit #(
  parameter int NSRC           = 3,
  parameter int PIPE_DEPTH     = 3,
  parameter int LOAD_READY_IDX = 1,
  parameter int SEL_W          = 2,
  parameter int CNT_W          = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  hazard_scoreboard_unit_if.slave  bus
);

  // Scoreboard entries; only the valid bits are control and get reset.
  logic [PIPE_DEPTH-1:0] r_v;
  logic [PIPE_DEPTH-1:0] r_we;
  logic [PIPE_DEPTH-1:0] r_ld;
  logic [4:0]            r_dest [PIPE_DEPTH];
  logic [CNT_W-1:0]      r_stall_cnt;

  logic [PIPE_DEPTH-1:0]   w_writer;
  logic [NSRC-1:0]         w_ld_use;
  logic [NSRC*SEL_W-1:0]   w_fwd_sel;
  logic                    w_raw_stall;
  logic                    w_ds_stall;
  logic                    w_issue;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  genvar gk, gi;
  for (gk = 0; gk < PIPE_DEPTH; gk++) begin : g_writer
    assign w_writer[gk] = r_v[gk] & r_we[gk] & (r_dest[gk] != 5'd0);
  end

  for (gi = 0; gi < NSRC; gi++) begin : g_src
    logic [4:0]       w_src;
    logic [SEL_W-1:0] w_sel;
    logic             w_lu;
    assign w_src = bus.ds_src[5*gi +: 5];
    // Youngest matching writer wins: scan oldest to youngest, last hit sticks.
    always_comb begin
      w_sel = '0;
      w_lu  = 1'b0;
      if (bus.ds_src_en[gi] && (w_src != 5'd0)) begin
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
          if (w_writer[k] && (r_dest[k] == w_src)) begin
            w_sel = SEL_W'(k + 1);
            w_lu  = r_ld[k] && (k < LOAD_READY_IDX);
          end
        end
      end
    end
    assign w_fwd_sel[gi*SEL_W +: SEL_W] = w_sel;
    assign w_ld_use[gi]                 = w_lu;
  end

  assign w_raw_stall = |w_ld_use;
  assign w_ds_stall  = bus.ds_valid & (w_raw_stall | bus.mdu_busy) & ~bus.flush;
  assign w_issue     = bus.ds_valid & ~w_ds_stall & bus.pipe_adv & ~bus.flush;

  assign bus.ds_stall  = w_ds_stall;
  assign bus.es_bubble = w_ds_stall & bus.pipe_adv & ~bus.mdu_busy;
  assign bus.fwd_sel   = w_fwd_sel;
  assign bus.stall_cnt = r_stall_cnt;

  // Entry valid bits: reset/flush clear, otherwise shift on pipeline advance.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_v <= '0;
    end else if (bus.flush) begin
      r_v <= '0;
    end else if (bus.pipe_adv) begin
      r_v <= {r_v[PIPE_DEPTH-2:0], w_issue};
    end
  end

  // Entry payload shifts with the valid bits; a bubble carries we=0, ld=0.
  always_ff @(posedge clk) begin
    if (bus.pipe_adv && !bus.flush) begin
      r_we      <= {r_we[PIPE_DEPTH-2:0], w_issue & bus.ds_we};
      r_ld      <= {r_ld[PIPE_DEPTH-2:0], w_issue & bus.ds_is_load};
      r_dest[0] <= bus.ds_dest;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        r_dest[k] <= r_dest[k-1];
      end
    end
  end

  // Count decode-stall cycles, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (bus.ds_valid && w_ds_stall) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

endmodule
